// File: rtl/mem_rw_pkg.sv
// Shared widths, controller state encoding and request record for the
// write-verify memory front end.
package mem_rw_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RDBACK,
    ST_CHECK,
    ST_READ,
    ST_CAPT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port DEPTH x DATA_W RAM with a registered read port (read-old-data).
module mem_sp_ram
  import mem_rw_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int DP = DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // NOTE: the storage array has no reset; clearing every word would turn it
  // into a register file and stop it mapping onto a RAM macro.
  logic [DW-1:0] mem_q [DP];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_wr_verify_ctrl.sv
// Request front end for the single-port RAM: serves reads, and reads back
// every write to flag (sticky) the first address whose data did not stick.
module mem_wr_verify_ctrl
  import mem_rw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  state_e            state_q;
  req_t              req_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic chk_fail;
  assign chk_fail = (state_q == ST_CHECK) && req_q.we && (mem_rdata != req_q.wdata);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      // A mismatch in the same cycle as err_clr wins and is recorded afresh.
      if (chk_fail) begin
        error_q <= 1'b1;
        if (!error_q || err_clr) begin
          err_addr_q <= req_q.addr;
        end
      end else if (err_clr) begin
        error_q    <= 1'b0;
        err_addr_q <= '0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_q       <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            req_ready_q <= 1'b0;
            mem_addr_q  <= req_addr;
            if (req_we) begin
              state_q     <= ST_WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q <= ST_READ;
            end
          end else begin
            req_ready_q <= 1'b1;
            mem_addr_q  <= '0;
          end
        end
        ST_WRITE: begin
          mem_we_q <= 1'b0;
          state_q  <= ST_RDBACK;
        end
        ST_RDBACK: state_q <= ST_CHECK;
        ST_CHECK: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          mem_addr_q  <= '0;
        end
        ST_READ: state_q <= ST_CAPT;
        ST_CAPT: begin
          rsp_rdata_q <= mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            mem_addr_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_wr_verify_ctrl.sv
// Directed bench for mem_wr_verify_ctrl beside mem_sp_ram; the RAM input path
// corrupts bit 0 of writes to 0x10 and 0x20 to provoke readback mismatches.
module tb_mem_wr_verify_ctrl;
  import mem_rw_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_clr;
  logic              error;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] ram_wdata;

  int checks_total  = 0;
  int checks_passed = 0;

  mem_wr_verify_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_clr(err_clr), .error(error), .err_addr(err_addr)
  );

  assign ram_wdata = mem_wdata ^ {{(DATA_W-1){1'b0}},
                                  (mem_addr == 8'h10) || (mem_addr == 8'h20)};

  mem_sp_ram ram (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(ram_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) break;
      step();
    end
    check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  // Single write: checks the 4-cycle handshake-to-ready sequence.
  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    wait_ready(tag);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    check({tag, "_we_hi"},  32'(mem_we),    32'd1);
    check({tag, "_addr"},   32'(mem_addr),  32'(a));
    check({tag, "_wdata"},  32'(mem_wdata), 32'(d));
    check({tag, "_busy"},   32'(req_ready), 32'd0);
    step();
    check({tag, "_we_lo"},  32'(mem_we),    32'd0);
    check({tag, "_rb_addr"}, 32'(mem_addr), 32'(a));
    step();
    step();
    check({tag, "_done"},   32'(req_ready), 32'd1);
  endtask

  // Single read with rsp_ready held low for 'hold' cycles after rsp_valid.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp,
                         input int hold);
    wait_ready(tag);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'hEE;
    step();
    req_valid = 1'b0;
    check({tag, "_addr"},  32'(mem_addr), 32'(a));
    check({tag, "_no_we"}, 32'(mem_we),   32'd0);
    step();
    check({tag, "_early"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"},  32'(rsp_rdata), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"},  32'(rsp_rdata), 32'(exp));
      check({tag, "_hold_busy"},  32'(req_ready), 32'd0);
    end
    check({tag, "_pre_hs_busy"}, 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready"},    32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_err_addr",  32'(err_addr),  32'd0);
    rst_n = 1'b1;
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Basic write/write/read at 0x05.
    do_write("w05a", 8'h05, 8'h00);
    do_write("w05b", 8'h05, 8'h05);
    check("w05_error", 32'(error), 32'd0);
    do_read("r05", 8'h05, 8'h05, 0);

    // Fault injection: first failure is kept, clear, then clear-vs-mismatch.
    do_write("w10", 8'h10, 8'hA5);
    check("f10_error",    32'(error),    32'd1);
    check("f10_err_addr", 32'(err_addr), 32'h10);
    do_write("w20", 8'h20, 8'h55);
    check("f20_error",    32'(error),    32'd1);
    check("f20_err_addr", 32'(err_addr), 32'h10);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_error",    32'(error),    32'd0);
    check("clr_err_addr", 32'(err_addr), 32'd0);
    do_write("w10b", 8'h10, 8'h3C);
    err_clr = 1'b1;
    do_write("w20c", 8'h20, 8'h55);
    err_clr = 1'b0;
    check("clrwin_error",    32'(error),    32'd1);
    check("clrwin_err_addr", 32'(err_addr), 32'h20);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr2_error", 32'(error), 32'd0);

    // Backpressure on the response channel.
    do_write("w33", 8'h33, 8'h3C);
    do_read("r33", 8'h33, 8'h3C, 3);

    // Address boundaries.
    do_write("wff", 8'hFF, 8'h7E);
    do_write("w00", 8'h00, 8'h81);
    do_read("rff", 8'hFF, 8'h7E, 0);
    do_read("r00", 8'h00, 8'h81, 1);

    // Reset in the middle of a write, with the error flag set beforehand.
    do_write("w10c", 8'h10, 8'hA5);
    check("pre_rst_error", 32'(error), 32'd1);
    wait_ready("mid");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h44; req_wdata = 8'h11;
    step();
    req_valid = 1'b0;
    check("mid_in_write", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_mem_we",    32'(mem_we),    32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_error",     32'(error),     32'd0);
    check("mid_err_addr",  32'(err_addr),  32'd0);
    rst_n = 1'b1;
    step();
    check("mid_ready", 32'(req_ready), 32'd1);
    step();
    check("mid_idle_we", 32'(mem_we), 32'd0);

    // Back-to-back writes with req_valid held high.
    wait_ready("b2b");
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'(8'h60 + i); req_wdata = 8'(8'hA0 + i);
      check("b2b_ready_pulse", 32'(req_ready), 32'd1);
      step();
      check("b2b_we",      32'(mem_we),    32'd1);
      check("b2b_wdata",   32'(mem_wdata), 32'(8'hA0 + i));
      check("b2b_busy1",   32'(req_ready), 32'd0);
      step();
      check("b2b_busy2",   32'(req_ready), 32'd0);
      step();
      check("b2b_busy3",   32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    check("b2b_final_ready", 32'(req_ready), 32'd1);
    check("b2b_error",       32'(error),     32'd0);
    do_read("r61", 8'h61, 8'hA1, 0);
    do_read("r63", 8'h63, 8'hA3, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
